// File: rtl/jb_predict_resolve.sv
// Decode-stage jump/branch unit: direct-mapped BTB with 2-bit counters, ID-stage
// resolution, mispredict redirect and load-use stall. Optional counters: JB_STATS_EN.
module jb_predict_resolve #(
  parameter int XLEN         = 32,
  parameter int BTB_IDX_BITS = 4,
  parameter int TAG_BITS     = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  output logic [XLEN-1:0] if_pred_target,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic            id_pred_taken,
  input  logic [XLEN-1:0] id_pred_target,
  input  logic [1:0]      jb_sel,
  input  logic [2:0]      cmpop,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] b_imm,
  input  logic [XLEN-1:0] j_imm,
  input  logic [XLEN-1:0] i_imm,
  input  logic            ex_load_valid,
  input  logic [4:0]      ex_load_rd,
`ifdef JB_STATS_EN
  output logic [31:0]     stat_resolved,
  output logic [31:0]     stat_mispredict,
`endif
  output logic            stall,
  output logic            pc_mux_sel,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush
);

  localparam int ENTRIES = 1 << BTB_IDX_BITS;
  localparam int TAG_LO  = BTB_IDX_BITS + 2;
  localparam int TAG_HI  = BTB_IDX_BITS + TAG_BITS + 1;

  localparam logic [1:0] SEL_BRANCH = 2'b00;
  localparam logic [1:0] SEL_JAL    = 2'b01;
  localparam logic [1:0] SEL_JALR   = 2'b10;
  localparam logic [1:0] SEL_NONE   = 2'b11;

  logic                valid_reg  [ENTRIES];
  logic [TAG_BITS-1:0] tag_reg    [ENTRIES];
  logic [XLEN-1:0]     target_reg [ENTRIES];
  logic [1:0]          ctr_reg    [ENTRIES];

  logic [BTB_IDX_BITS-1:0] if_idx, id_idx;
  logic [TAG_BITS-1:0]     if_tag, id_tag;
  logic                    if_hit, id_hit, lookup_taken;

  assign if_idx = if_pc[TAG_LO-1:2];
  assign if_tag = if_pc[TAG_HI:TAG_LO];
  assign id_idx = id_pc[TAG_LO-1:2];
  assign id_tag = id_pc[TAG_HI:TAG_LO];

  // Lookup reads the arrays before any same-cycle update lands.
  assign if_hit       = valid_reg[if_idx] && (tag_reg[if_idx] == if_tag);
  assign lookup_taken = if_hit && ctr_reg[if_idx][1];
  assign id_hit       = valid_reg[id_idx] && (tag_reg[id_idx] == id_tag);

  logic stall_raw, resolve, br_taken, taken, mispredict;
  logic [XLEN-1:0] target, next_pc;

  always_comb begin
    stall_raw = 1'b0;
    if (id_valid && ex_load_valid && (ex_load_rd != 5'd0) && (jb_sel != SEL_NONE))
      stall_raw = (ex_load_rd == id_rs1) ||
                  ((ex_load_rd == id_rs2) && (jb_sel == SEL_BRANCH));
  end

  assign resolve = id_valid && !stall_raw && (jb_sel != SEL_NONE);

  always_comb begin
    br_taken = 1'b0;
    case (cmpop)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val <  rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    taken  = 1'b0;
    target = '0;
    case (jb_sel)
      SEL_BRANCH: begin
        taken  = br_taken;
        target = id_pc + b_imm;
      end
      SEL_JAL: begin
        taken  = 1'b1;
        target = id_pc + j_imm;
      end
      SEL_JALR: begin
        taken  = 1'b1;
        target = (rs1_val + i_imm) & ~XLEN'(1);
      end
      default: begin
        taken  = 1'b0;
        target = '0;
      end
    endcase
  end

  assign next_pc    = taken ? target : (id_pc + XLEN'(4));
  assign mispredict = resolve &&
                      ((taken != id_pred_taken) || (taken && (target != id_pred_target)));

  assign if_pred_taken  = rst_n && lookup_taken;
  assign if_pred_target = (rst_n && lookup_taken) ? target_reg[if_idx] : '0;
  assign stall          = rst_n && stall_raw;
  assign pc_mux_sel     = rst_n && mispredict;
  assign flush          = rst_n && mispredict;
  assign redirect_pc    = (rst_n && mispredict) ? next_pc : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) valid_reg[i] <= 1'b0;
    end else if (resolve && !id_hit && taken) begin
      valid_reg[id_idx] <= 1'b1;
    end
  end

  // Payload fields are only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (rst_n && resolve) begin
      if (id_hit) begin
        if (taken) begin
          ctr_reg[id_idx]    <= (ctr_reg[id_idx] == 2'd3) ? 2'd3 : ctr_reg[id_idx] + 2'd1;
          target_reg[id_idx] <= target;
        end else begin
          ctr_reg[id_idx] <= (ctr_reg[id_idx] == 2'd0) ? 2'd0 : ctr_reg[id_idx] - 2'd1;
        end
      end else if (taken) begin
        tag_reg[id_idx]    <= id_tag;
        target_reg[id_idx] <= target;
        ctr_reg[id_idx]    <= 2'd2;
      end
    end
  end

`ifdef JB_STATS_EN
  logic [31:0] resolved_reg, mispredict_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resolved_reg   <= '0;
      mispredict_reg <= '0;
    end else begin
      if (resolve && (resolved_reg != 32'hFFFF_FFFF))
        resolved_reg <= resolved_reg + 32'd1;
      if (mispredict && (mispredict_reg != 32'hFFFF_FFFF))
        mispredict_reg <= mispredict_reg + 32'd1;
    end
  end

  assign stat_resolved   = rst_n ? resolved_reg   : '0;
  assign stat_mispredict = rst_n ? mispredict_reg : '0;
`endif

  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, if_pc[1:0], id_pc[1:0], if_pc[XLEN-1:TAG_HI+1],
                            id_pc[XLEN-1:TAG_HI+1]};

endmodule

// File: tb/tb_jb_predict_resolve.sv
// Directed bench for jb_predict_resolve: BTB allocation, counter hysteresis,
// jalr alignment, load-use stall, mid-run reset and signed/unsigned compares.
module tb_jb_predict_resolve;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic        id_valid;
  logic [31:0] id_pc;
  logic        id_pred_taken;
  logic [31:0] id_pred_target;
  logic [1:0]  jb_sel;
  logic [2:0]  cmpop;
  logic [4:0]  id_rs1, id_rs2;
  logic [31:0] rs1_val, rs2_val, b_imm, j_imm, i_imm;
  logic        ex_load_valid;
  logic [4:0]  ex_load_rd;
  logic        stall, pc_mux_sel, flush;
  logic [31:0] redirect_pc;
`ifdef JB_STATS_EN
  logic [31:0] stat_resolved, stat_mispredict;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jb_predict_resolve dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .if_pred_target(if_pred_target), .id_valid(id_valid), .id_pc(id_pc),
    .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target), .jb_sel(jb_sel),
    .cmpop(cmpop), .id_rs1(id_rs1), .id_rs2(id_rs2), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .b_imm(b_imm), .j_imm(j_imm), .i_imm(i_imm), .ex_load_valid(ex_load_valid),
    .ex_load_rd(ex_load_rd),
`ifdef JB_STATS_EN
    .stat_resolved(stat_resolved), .stat_mispredict(stat_mispredict),
`endif
    .stall(stall), .pc_mux_sel(pc_mux_sel), .redirect_pc(redirect_pc), .flush(flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    id_valid = 1'b0; ex_load_valid = 1'b0; ex_load_rd = 5'd0;
    jb_sel = 2'b11; id_rs1 = 5'd0; id_rs2 = 5'd0;
  endtask

  task automatic set_br(input logic [31:0] pc, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm,
                        input logic pt, input logic [31:0] ptgt);
    id_valid = 1'b1; jb_sel = 2'b00; id_pc = pc; cmpop = op; rs1_val = a; rs2_val = b;
    b_imm = imm; id_pred_taken = pt; id_pred_target = ptgt;
  endtask

  task automatic set_jalr(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt);
    id_valid = 1'b1; jb_sel = 2'b10; id_pc = pc; rs1_val = 32'h2001; i_imm = 32'h4;
    id_pred_taken = pt; id_pred_target = ptgt;
  endtask

  task automatic chk_redir(input string tag, input logic f, input logic [31:0] pc);
    chk({tag, ".flush"}, {31'd0, flush}, {31'd0, f});
    chk({tag, ".pc_mux_sel"}, {31'd0, pc_mux_sel}, {31'd0, f});
    chk({tag, ".redirect_pc"}, redirect_pc, pc);
  endtask

  task automatic chk_pred(input string tag, input logic t, input logic [31:0] tgt);
    chk({tag, ".pred_taken"}, {31'd0, if_pred_taken}, {31'd0, t});
    chk({tag, ".pred_target"}, if_pred_target, tgt);
  endtask

  initial begin
    rst_n = 1'b0; if_pc = 32'h100; idle();
    id_pc = '0; id_pred_taken = 1'b0; id_pred_target = '0; cmpop = '0;
    rs1_val = '0; rs2_val = '0; b_imm = '0; j_imm = '0; i_imm = '0;
    tick(); tick();

    // Outputs forced low in reset even with a mispredicting, stalling ID
    set_br(32'h100, 3'b000, 5, 5, 32'h20, 1'b0, 0);
    ex_load_valid = 1'b1; ex_load_rd = 5'd3; id_rs1 = 5'd3;
    #1;
    chk("reset.stall", {31'd0, stall}, 0);
    chk_redir("reset", 1'b0, 0);
    tick();
    rst_n = 1'b1; idle();

    // Cold lookup
    if_pc = 32'h100; #1;
    chk_pred("cold", 1'b0, 0);

    // beq mispredict then allocate
    set_br(32'h100, 3'b000, 5, 5, 32'h20, 1'b0, 0); #1;
    chk("beq.stall", {31'd0, stall}, 0);
    chk_redir("beq_alloc", 1'b1, 32'h120);
    tick(); idle(); #1;
    chk_pred("after_alloc", 1'b1, 32'h120);
    chk_redir("idle", 1'b0, 0);

    // Two correctly predicted takens (ctr 2->3->3)
    for (int k = 0; k < 2; k++) begin
      set_br(32'h100, 3'b000, 5, 5, 32'h20, 1'b1, 32'h120); #1;
      chk_redir($sformatf("taken_ok%0d", k), 1'b0, 0);
      tick();
    end

    // First not-taken: ctr 3->2, still predicts taken
    set_br(32'h100, 3'b000, 5, 6, 32'h20, 1'b1, 32'h120); #1;
    chk_redir("nt1", 1'b1, 32'h104);
    tick(); idle(); #1;
    chk_pred("hyst_ctr2", 1'b1, 32'h120);

    // Second not-taken: lookup same cycle sees pre-update ctr=2; next cycle ctr=1
    set_br(32'h100, 3'b000, 5, 6, 32'h20, 1'b1, 32'h120); #1;
    chk_redir("nt2", 1'b1, 32'h104);
    chk_pred("same_cycle", 1'b1, 32'h120);
    tick(); idle(); #1;
    chk_pred("hyst_ctr1", 1'b0, 0);

    // jalr alignment at 0x204 (separate BTB index)
    set_jalr(32'h204, 1'b0, 0); #1;
    chk_redir("jalr_mp", 1'b1, 32'h2004);
    tick();
    if_pc = 32'h204;
    set_jalr(32'h204, 1'b1, 32'h2004); #1;
    chk_redir("jalr_ok", 1'b0, 0);
    chk_pred("jalr_lookup", 1'b1, 32'h2004);
    tick(); idle();

    // Load-use stall on rs1 for a mispredicting branch at 0x308
    if_pc = 32'h308;
    set_br(32'h308, 3'b000, 5, 5, 32'h20, 1'b0, 0);
    id_rs1 = 5'd3; ex_load_valid = 1'b1; ex_load_rd = 5'd3; #1;
    chk("lu.stall", {31'd0, stall}, 1);
    chk_redir("lu", 1'b0, 0);
    tick();
    ex_load_valid = 1'b0; #1;
    chk("lu_rel.stall", {31'd0, stall}, 0);
    chk_redir("lu_rel", 1'b1, 32'h328);
    chk_pred("lu_no_write", 1'b0, 0);
    tick(); idle();

    // rs2 match only stalls branches; jb_sel=11 never stalls
    id_valid = 1'b1; jb_sel = 2'b01; id_pc = 32'h30C; j_imm = 32'h10;
    id_pred_taken = 1'b1; id_pred_target = 32'h31C;
    id_rs1 = 5'd4; id_rs2 = 5'd3; ex_load_valid = 1'b1; ex_load_rd = 5'd3; #1;
    chk("jal_rs2.stall", {31'd0, stall}, 0);
    chk_redir("jal_ok", 1'b0, 0);
    jb_sel = 2'b11; id_rs1 = 5'd3; #1;
    chk("none.stall", {31'd0, stall}, 0);
    tick(); idle();

    // Re-train 0x100 to taken so it is valid and predicting before reset
    set_br(32'h100, 3'b000, 7, 7, 32'h20, 1'b0, 0); #1;
    chk_redir("retrain", 1'b1, 32'h120);
    tick(); idle(); if_pc = 32'h100; #1;
    chk_pred("pre_reset", 1'b1, 32'h120);

    // Mid-operation reset during a mispredict
    set_jalr(32'h204, 1'b0, 0); rst_n = 1'b0; #1;
    chk_redir("mid_reset", 1'b0, 0);
    chk_pred("mid_reset", 1'b0, 0);
    tick(); rst_n = 1'b1; idle(); #1;
    chk_pred("post_reset_100", 1'b0, 0);
    if_pc = 32'h204; #1;
    chk_pred("post_reset_204", 1'b0, 0);

    // blt vs bltu
    set_br(32'h400, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h40, 1'b0, 0); #1;
    chk_redir("blt", 1'b1, 32'h440);
    tick();
    set_br(32'h400, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h40, 1'b0, 0); #1;
    chk_redir("bltu", 1'b0, 0);
    tick();

    // Undefined cmpop resolves not-taken
    set_br(32'h400, 3'b010, 5, 5, 32'h40, 1'b1, 32'h440); #1;
    chk_redir("undef_cmp", 1'b1, 32'h404);
    tick();

    // jal with negative offset
    id_valid = 1'b1; jb_sel = 2'b01; id_pc = 32'h500; j_imm = 32'hFFFF_FF00;
    id_pred_taken = 1'b0; id_pred_target = 0; #1;
    chk_redir("jal_neg", 1'b1, 32'h400);
    tick(); idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jb_predict_resolve.md
Name: jb_predict_resolve

Overview:
- Decode-stage jump/branch unit with a direct-mapped branch target buffer (BTB) and 2-bit direction counters.
- IF stage: looks up the BTB combinationally to get a predicted direction and target.
- ID stage: resolves the branch, jal or jalr, compares the result against the prediction carried down the pipe, and on mismatch redirects the PC and flushes.
- Also detects load-use hazards on the ID source registers and stalls.

Parameters:
XLEN, 32, datapath/PC width.
BTB_IDX_BITS, 4, log2 of BTB entries (default 16 entries); index = pc[BTB_IDX_BITS+1:2].
TAG_BITS, 8, tag width; tag = pc[BTB_IDX_BITS+TAG_BITS+1:BTB_IDX_BITS+2].

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous active-low reset.
if_pc  in  XLEN  fetch PC for BTB lookup.
if_pred_taken  out  1  prediction for if_pc.
if_pred_target  out  XLEN  predicted target (0 when if_pred_taken=0).
id_valid  in  1  ID holds a real instruction.
id_pc  in  XLEN  ID instruction PC.
id_pred_taken  in  1  prediction made for this instruction in IF.
id_pred_target  in  XLEN  predicted target made in IF.
jb_sel  in  2  00 branch, 01 jal, 10 jalr, 11 not jump/branch.
cmpop  in  3  branch funct3: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu.
id_rs1, id_rs2  in  5 each  source register numbers.
rs1_val, rs2_val  in  XLEN each  register-file read data.
b_imm, j_imm, i_imm  in  XLEN each  sign-extended immediates.
ex_load_valid  in  1  EX holds a load.
ex_load_rd  in  5  destination of that load.
stall  out  1  hold IF/ID this cycle.
pc_mux_sel  out  1  select redirect_pc as next PC.
redirect_pc  out  XLEN  corrected PC.
flush  out  1  squash IF/ID contents.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - all BTB valid bits cleared; counters and tags need no reset.
  - while rst_n=0, every output is forced to 0.
- Lookup (combinational):
  - hit = valid[idx] & tag match.
  - if_pred_taken = hit & ctr[idx][1].
  - if_pred_target = stored target when if_pred_taken, else 0.
- Hazard:
  - stall = id_valid & ex_load_valid & ex_load_rd!=0 & (ex_load_rd==id_rs1 | (ex_load_rd==id_rs2 & jb_sel==00)).
  - For jb_sel==11, stall is driven 0.
  - While stall=1: no resolution, no redirect, no BTB write.
- Resolution happens when resolve = id_valid & !stall & jb_sel!=11.
  - Branch: taken from a signed or unsigned compare per cmpop. Undefined cmpop (010, 011) resolves not-taken. Target = id_pc + b_imm.
  - jal: always taken; target = id_pc + j_imm.
  - jalr: always taken; target = (rs1_val + i_imm) & ~1.
  - All additions are modulo 2^XLEN.
  - Correct next PC = target if taken, else id_pc + 4.
- Mispredict:
  - mispredict = resolve & (taken != id_pred_taken | (taken & target != id_pred_target)).
  - pc_mux_sel = flush = mispredict, combinational in the same cycle.
  - redirect_pc = correct next PC when mispredicting, else 0.
- BTB update, at the rising edge when resolve:
  - Entry hit and taken: ctr saturating increment to 3; target rewritten.
  - Entry hit and not taken: ctr saturating decrement to 0.
  - Miss and taken: allocate (valid=1, tag, target, ctr=2), replacing the occupant.
  - Miss and not taken: no write.
- Same-cycle lookup and update to the same index: the lookup returns pre-update contents; the write is visible from the next cycle.
- id_valid=0: no stall, no redirect, no update.
- Reset asserted mid-stall or mid-redirect: outputs 0 that cycle; BTB empty afterwards.

Optional Feature:
- Macro: JB_STATS_EN.
- When defined, adds two outputs:
  - stat_resolved [31:0]: counts resolve cycles.
  - stat_mispredict [31:0]: counts mispredict cycles.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Cold BTB lookup:
  - Stimulus: after reset, if_pc=0x100.
  - Response: if_pred_taken=0, if_pred_target=0.
- beq mispredict then allocate:
  - Stimulus: id_pc=0x100, beq, rs1_val=rs2_val=5, b_imm=0x20, id_pred_taken=0.
  - Response: same cycle flush=pc_mux_sel=1, redirect_pc=0x120. Next cycle if_pc=0x100 gives if_pred_taken=1, if_pred_target=0x120.
- Counter saturation and hysteresis:
  - Stimulus: same branch at 0x100 resolved taken twice, then not-taken once with id_pred_taken=1.
  - Response: redirect_pc=0x104, flush=1. Lookup still predicts taken (ctr=2). A second not-taken gives ctr=1, so predict 0.
- jalr target alignment:
  - Stimulus: rs1_val=0x2001, i_imm=0x4, id_pred_taken=0.
  - Response: redirect_pc=0x2004. A following correct prediction (id_pred_target=0x2004) gives flush=0.
- Load-use stall:
  - Stimulus: ex_load_valid=1, ex_load_rd=3, id_rs1=3, branch that would mispredict.
  - Response: stall=1, flush=0, no BTB change. Next cycle with ex_load_valid=0 the branch resolves and redirects.
- Mid-operation reset and blt/bltu compare:
  - Reset stimulus: rst_n=0 during a mispredict.
  - Reset response: all outputs 0; afterwards the previously allocated 0x100 entry misses.
  - Compare stimulus: blt vs bltu with rs1_val=0xFFFFFFFF, rs2_val=1.
  - Compare response: blt taken, bltu not taken.
